// File: rtl/logic_unit_pkg.sv
// Shared constants and types for the 8-bit bitwise logic unit and its operand loader.
// The logic unit reuses WIDTH_DEFAULT so both stages agree on the lane count.
package logic_unit_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        PRESENT = 2'd2
    } loader_state_t;

endpackage : logic_unit_pkg

// File: rtl/operand_loader_if.sv
// Operand beat input stream plus the parallel a/b pair handshake towards the logic unit.
// master = the surrounding environment, slave = the loader itself.
interface operand_loader_if
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             op_valid;
    logic             op_ready;

    modport master (
        output in_data, in_valid, op_ready,
        input  in_ready, a, b, op_valid
    );

    modport slave (
        input  in_data, in_valid, op_ready,
        output in_ready, a, b, op_valid
    );

endinterface : operand_loader_if

// File: rtl/operand_loader.sv
// Collects operands A and B as two beats on one bus and presents them together,
// held stable, until downstream consumes the pair; counts completed pairs mod 256.
module operand_loader
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   abort,
    operand_loader_if.slave        bus,
    output logic [7:0]             pair_count
);

    loader_state_t    state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [7:0]       pair_count_q, pair_count_d;
    logic             in_ready_c;
    logic             op_valid_c;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        pair_count_d = pair_count_q;
        in_ready_c   = 1'b0;
        op_valid_c   = 1'b0;

        // Abort outranks both handshakes: nothing is captured or consumed this cycle.
        if (abort) begin
            state_d = LOAD_A;
            a_d     = '0;
            b_d     = '0;
        end else begin
            unique case (state_q)
                LOAD_A: begin
                    in_ready_c = 1'b1;
                    if (bus.in_valid) begin
                        a_d     = bus.in_data;
                        state_d = LOAD_B;
                    end
                end
                LOAD_B: begin
                    in_ready_c = 1'b1;
                    if (bus.in_valid) begin
                        b_d     = bus.in_data;
                        state_d = PRESENT;
                    end
                end
                PRESENT: begin
                    op_valid_c = 1'b1;
                    if (bus.op_ready) begin
                        pair_count_d = pair_count_q + 8'd1;
                        state_d      = LOAD_A;
                    end
                end
                default: begin
                    state_d = LOAD_A;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= LOAD_A;
            a_q          <= '0;
            b_q          <= '0;
            pair_count_q <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            pair_count_q <= pair_count_d;
        end
    end

    // Ready/valid depend only on registered state and abort, never on in_valid or op_ready.
    assign bus.in_ready = in_ready_c;
    assign bus.op_valid = op_valid_c;
    assign bus.a        = a_q;
    assign bus.b        = b_q;
    assign pair_count   = pair_count_q;

endmodule : operand_loader

// File: tb/tb_operand_loader.sv
// Self-checking bench for operand_loader: a directed vector table plus hand-written
// sequences for backpressure, mid-pair reset and pair counter wrap.
module tb_operand_loader;
    import logic_unit_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       abort;
    logic [7:0] pair_count;

    int n_checks;
    int n_pass;

    operand_loader_if #(.WIDTH(8)) bus ();

    operand_loader #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .abort      (abort),
        .bus        (bus),
        .pair_count (pair_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    typedef struct packed {
        logic       abort;
        logic       in_valid;
        logic [7:0] in_data;
        logic       op_ready;
        logic       exp_in_ready;
        logic       exp_op_valid;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
        logic [7:0] exp_count;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vec [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Drive one cycle's inputs at the falling edge; outputs are sampled 1 ns later.
    task automatic drive(input logic ab, input logic v, input logic [7:0] d, input logic r);
        @(negedge clk);
        abort        = ab;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.op_ready = r;
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic ir, input logic ov,
                                 input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] ec);
        check({tag, " in_ready"},   32'(bus.in_ready), 32'(ir));
        check({tag, " op_valid"},   32'(bus.op_valid), 32'(ov));
        check({tag, " a"},          32'(bus.a),        32'(ea));
        check({tag, " b"},          32'(bus.b),        32'(eb));
        check({tag, " pair_count"}, 32'(pair_count),   32'(ec));
    endtask

    task automatic do_pair(input logic [7:0] av, input logic [7:0] bv);
        drive(1'b0, 1'b1, av, 1'b0);
        drive(1'b0, 1'b1, bv, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b1);
    endtask

    initial begin
        logic [7:0] nand_v;
        n_checks = 0;
        n_pass   = 0;

        //            abort v  data   rdy  ir   ov   a      b      cnt
        vec[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'd0}; // reset state
        vec[1]  = '{1'b0, 1'b1, 8'hF0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'd0}; // A beat
        vec[2]  = '{1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 8'hF0, 8'h00, 8'd0}; // B beat
        vec[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hF0, 8'h3C, 8'd0}; // present, consumed
        vec[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hF0, 8'h3C, 8'd1}; // operands held
        vec[5]  = '{1'b0, 1'b1, 8'h12, 1'b0, 1'b1, 1'b0, 8'hF0, 8'h3C, 8'd1}; // gapped: A
        vec[6]  = '{1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h12, 8'h3C, 8'd1}; // gap
        vec[7]  = '{1'b0, 1'b0, 8'hEE, 1'b0, 1'b1, 1'b0, 8'h12, 8'h3C, 8'd1}; // gap
        vec[8]  = '{1'b0, 1'b1, 8'h34, 1'b0, 1'b1, 1'b0, 8'h12, 8'h3C, 8'd1}; // gapped: B
        vec[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h12, 8'h34, 8'd1}; // present, held
        vec[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h12, 8'h34, 8'd1}; // consumed
        vec[11] = '{1'b0, 1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 8'h12, 8'h34, 8'd2}; // A=0x77
        vec[12] = '{1'b1, 1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 8'h77, 8'h34, 8'd2}; // abort in LOAD_B
        vec[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'd2}; // back in LOAD_A, zeroed
        vec[14] = '{1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'd2}; // A
        vec[15] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h5A, 8'h00, 8'd2}; // B
        vec[16] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h5A, 8'hA5, 8'd2}; // abort in PRESENT
        vec[17] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'd2}; // not consumed

        rst_n        = 1'b0;
        abort        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.op_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vec[i].abort, vec[i].in_valid, vec[i].in_data, vec[i].op_ready);
            check_outputs($sformatf("vec%0d", i), vec[i].exp_in_ready, vec[i].exp_op_valid,
                          vec[i].exp_a, vec[i].exp_b, vec[i].exp_count);
            if (i == 3) begin
                nand_v = ~(bus.a & bus.b);
                check("nand F0/3C", 32'(nand_v), 32'h0000_00CF);
            end
        end

        // Backpressure: a held 0x11 beat must wait until the pair is consumed.
        drive(1'b0, 1'b1, 8'hAA, 1'b0);
        drive(1'b0, 1'b1, 8'h55, 1'b0);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 8'h11, 1'b0);
            check_outputs($sformatf("bp%0d", i), 1'b0, 1'b1, 8'hAA, 8'h55, 8'd2);
        end
        drive(1'b0, 1'b1, 8'h11, 1'b1);
        check_outputs("bp consume", 1'b0, 1'b1, 8'hAA, 8'h55, 8'd2);
        drive(1'b0, 1'b1, 8'h11, 1'b0);
        check_outputs("bp next A", 1'b1, 1'b0, 8'hAA, 8'h55, 8'd3);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        check_outputs("bp A captured", 1'b1, 1'b0, 8'h11, 8'h55, 8'd3);

        // Asynchronous reset mid-pair (in LOAD_B), asserted away from any clock edge.
        rst_n = 1'b0;
        #1;
        check_outputs("rst in LOAD_B", 1'b1, 1'b0, 8'h00, 8'h00, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Counter wrap: 255 pairs, then the 256th wraps to zero, the 257th gives one.
        for (int i = 0; i < 255; i++) do_pair(8'(i), 8'(~i));
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        check("count after 255", 32'(pair_count), 32'd255);
        do_pair(8'hC3, 8'h81);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        check("count after 256", 32'(pair_count), 32'd0);
        do_pair(8'h0F, 8'hF0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        check("count after 257", 32'(pair_count), 32'd1);

        // Reset while a complete pair is being presented.
        drive(1'b0, 1'b1, 8'hDE, 1'b0);
        drive(1'b0, 1'b1, 8'hAD, 1'b0);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        check_outputs("present before rst", 1'b0, 1'b1, 8'hDE, 8'hAD, 8'd1);
        rst_n = 1'b0;
        #1;
        check_outputs("rst in PRESENT", 1'b1, 1'b0, 8'h00, 8'h00, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        check_outputs("after rst release", 1'b1, 1'b0, 8'h00, 8'h00, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_operand_loader
